// File: rtl/cal1d_pool_pkg.sv
// Shared widths and state encoding for the fp17 pooling sequencer.
`default_nettype none

package cal1d_pool_pkg;

  localparam int FP17_W     = 17;
  localparam int POOL_LANES = 4;
  localparam int POOL_VEC_W = FP17_W * POOL_LANES;
  localparam int KW_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_ADD  = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4
  } pool_state_e;

endpackage

`default_nettype wire

// File: rtl/cal1d_fp16_pool_seq.sv
// Window-sum sequencer: accumulates K 4-lane fp17 vectors through an external
// adder, one addition in flight at a time, and emits the pooled sum.
`default_nettype none

module cal1d_fp16_pool_seq
  import cal1d_pool_pkg::*;
(
  input  logic                  autosa_op_gated_clk_fp16,
  input  logic                  autosa_core_rst,
  input  logic [KW_W-1:0]       cfg_kernel_width,
  input  logic                  pool_in_pvld,
  output logic                  pool_in_prdy,
  input  logic [POOL_VEC_W-1:0] pool_in_pd,
  input  logic                  pool_in_last,
  output logic                  sum_in_pvld,
  input  logic                  sum_in_prdy,
  output logic [POOL_VEC_W-1:0] sum_a_pd,
  output logic [POOL_VEC_W-1:0] sum_b_pd,
  input  logic                  sum_out_pvld,
  output logic                  sum_out_prdy,
  input  logic [POOL_VEC_W-1:0] sum_out_pd,
  output logic                  pool_out_pvld,
  input  logic                  pool_out_prdy,
  output logic [POOL_VEC_W-1:0] pool_out_pd
);

  pool_state_e           r_state;
  pool_state_e           w_next;
  logic [POOL_VEC_W-1:0] r_partial;
  logic [POOL_VEC_W-1:0] r_operand;
  logic [KW_W-1:0]       r_cnt;
  logic [KW_W-1:0]       r_klat;
  logic                  r_close;

  logic                  w_in_acc;
  logic                  w_open;
  logic                  w_open_to_out;
  logic [KW_W-1:0]       w_cnt_inc;

  // pool_in_prdy follows pool_out_prdy in OUT so a new window can open in
  // the same cycle the finished one is taken, without a bubble.
  assign pool_in_prdy  = (r_state == ST_IDLE) || (r_state == ST_HOLD) ||
                         ((r_state == ST_OUT) && pool_out_prdy);
  assign sum_in_pvld   = (r_state == ST_ADD);
  assign sum_out_prdy  = (r_state == ST_WAIT);
  assign pool_out_pvld = (r_state == ST_OUT);
  assign sum_a_pd      = r_partial;
  assign sum_b_pd      = r_operand;
  assign pool_out_pd   = r_partial;

  assign w_in_acc      = pool_in_pvld && pool_in_prdy;
  assign w_open        = w_in_acc && ((r_state == ST_IDLE) || (r_state == ST_OUT));
  assign w_open_to_out = (cfg_kernel_width == '0) || pool_in_last;
  assign w_cnt_inc     = r_cnt + 3'd1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_in_acc) w_next = w_open_to_out ? ST_OUT : ST_HOLD;
      ST_HOLD: if (w_in_acc) w_next = ST_ADD;
      ST_ADD:  if (sum_in_prdy) w_next = ST_WAIT;
      ST_WAIT: if (sum_out_pvld) w_next = ((w_cnt_inc == r_klat) || r_close) ? ST_OUT : ST_HOLD;
      ST_OUT: begin
        if (pool_out_prdy) begin
          if (w_in_acc) w_next = w_open_to_out ? ST_OUT : ST_HOLD;
          else          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge autosa_op_gated_clk_fp16) begin
    if (autosa_core_rst) r_state <= ST_IDLE;
    else                 r_state <= w_next;
  end

  always_ff @(posedge autosa_op_gated_clk_fp16) begin
    if (autosa_core_rst) begin
      r_partial <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_klat    <= '0;
      r_close   <= 1'b0;
    end else begin
      if (w_open) begin
        r_partial <= pool_in_pd;
        r_cnt     <= '0;
        r_klat    <= cfg_kernel_width;
        r_close   <= 1'b0;
      end
      if ((r_state == ST_HOLD) && w_in_acc) begin
        r_operand <= pool_in_pd;
        r_close   <= pool_in_last;
      end
      if ((r_state == ST_WAIT) && sum_out_pvld) begin
        r_partial <= sum_out_pd;
        r_cnt     <= w_cnt_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cal1d_fp16_pool_seq.sv
// Directed bench for cal1d_fp16_pool_seq with a behavioural lane-wise integer adder.
`default_nettype none

module tb_cal1d_fp16_pool_seq;
  import cal1d_pool_pkg::*;

  logic                  autosa_op_gated_clk_fp16;
  logic                  autosa_core_rst;
  logic [KW_W-1:0]       cfg_kernel_width;
  logic                  pool_in_pvld;
  logic                  pool_in_prdy;
  logic [POOL_VEC_W-1:0] pool_in_pd;
  logic                  pool_in_last;
  logic                  sum_in_pvld;
  logic                  sum_in_prdy;
  logic [POOL_VEC_W-1:0] sum_a_pd;
  logic [POOL_VEC_W-1:0] sum_b_pd;
  logic                  sum_out_pvld;
  logic                  sum_out_prdy;
  logic [POOL_VEC_W-1:0] sum_out_pd;
  logic                  pool_out_pvld;
  logic                  pool_out_prdy;
  logic [POOL_VEC_W-1:0] pool_out_pd;

  int compared   = 0;
  int mismatched = 0;
  int req_wait   = 0;
  int rsp_wait   = 0;
  logic rsp_busy;
  logic [POOL_VEC_W-1:0] req_a[$];
  logic [POOL_VEC_W-1:0] req_b[$];

  cal1d_fp16_pool_seq dut (
    .autosa_op_gated_clk_fp16(autosa_op_gated_clk_fp16),
    .autosa_core_rst(autosa_core_rst),
    .cfg_kernel_width(cfg_kernel_width),
    .pool_in_pvld(pool_in_pvld),
    .pool_in_prdy(pool_in_prdy),
    .pool_in_pd(pool_in_pd),
    .pool_in_last(pool_in_last),
    .sum_in_pvld(sum_in_pvld),
    .sum_in_prdy(sum_in_prdy),
    .sum_a_pd(sum_a_pd),
    .sum_b_pd(sum_b_pd),
    .sum_out_pvld(sum_out_pvld),
    .sum_out_prdy(sum_out_prdy),
    .sum_out_pd(sum_out_pd),
    .pool_out_pvld(pool_out_pvld),
    .pool_out_prdy(pool_out_prdy),
    .pool_out_pd(pool_out_pd)
  );

  initial autosa_op_gated_clk_fp16 = 1'b0;
  always #5 autosa_op_gated_clk_fp16 = ~autosa_op_gated_clk_fp16;

  function automatic logic [POOL_VEC_W-1:0] vec(input logic [FP17_W-1:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [POOL_VEC_W-1:0] lane_add(input logic [POOL_VEC_W-1:0] a,
                                                     input logic [POOL_VEC_W-1:0] b);
    logic [POOL_VEC_W-1:0] z;
    for (int l = 0; l < POOL_LANES; l++)
      z[l*FP17_W +: FP17_W] = a[l*FP17_W +: FP17_W] + b[l*FP17_W +: FP17_W];
    return z;
  endfunction

  task automatic step();
    @(posedge autosa_op_gated_clk_fp16);
    #1;
  endtask

  // Behavioural adder: optional request stall, optional response delay,
  // checks the operands stay put and no second request appears meanwhile.
  initial begin
    logic [POOL_VEC_W-1:0] a0, b0;
    sum_in_prdy  = 1'b0;
    sum_out_pvld = 1'b0;
    sum_out_pd   = '0;
    rsp_busy     = 1'b0;
    forever begin
      step();
      if (sum_in_pvld === 1'b1 && autosa_core_rst === 1'b0) begin
        rsp_busy = 1'b1;
        a0 = sum_a_pd;
        b0 = sum_b_pd;
        for (int i = 0; i < req_wait; i++) begin
          step();
          compared++;
          if (sum_in_pvld !== 1'b1 || sum_a_pd !== a0 || sum_b_pd !== b0) begin
            mismatched++;
            $display("FAIL req_hold: pvld=%b a=%h b=%h, required pvld=1 a=%h b=%h",
                     sum_in_pvld, sum_a_pd, sum_b_pd, a0, b0);
          end
        end
        sum_in_prdy = 1'b1;
        step();
        sum_in_prdy = 1'b0;
        req_a.push_back(a0);
        req_b.push_back(b0);
        for (int i = 0; i < rsp_wait; i++) begin
          step();
          compared++;
          if (sum_in_pvld !== 1'b0) begin
            mismatched++;
            $display("FAIL req_extra: sum_in_pvld=%b while adder busy, required 0", sum_in_pvld);
          end
        end
        sum_out_pvld = 1'b1;
        sum_out_pd   = lane_add(a0, b0);
        step();
        sum_out_pvld = 1'b0;
        rsp_busy     = 1'b0;
      end
    end
  end

  task automatic send(input logic [FP17_W-1:0] v, input logic last);
    int n = 0;
    pool_in_pvld = 1'b1;
    pool_in_pd   = vec(v);
    pool_in_last = last;
    while (pool_in_prdy !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: pool_in_prdy=%b, required 1 within 100 cycles", pool_in_prdy);
    end
    step();
    pool_in_pvld = 1'b0;
    pool_in_last = 1'b0;
  endtask

  task automatic get_out(input string name, input logic [FP17_W-1:0] exp);
    int n = 0;
    pool_out_prdy = 1'b1;
    while (pool_out_pvld !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    compared++;
    if (pool_out_pvld !== 1'b1 || pool_out_pd !== vec(exp)) begin
      mismatched++;
      $display("FAIL %s: pvld=%b pd=%h, required pvld=1 pd=%h", name, pool_out_pvld,
               pool_out_pd, vec(exp));
    end
    step();
    pool_out_prdy = 1'b0;
  endtask

  task automatic wait_adder_idle();
    int n = 0;
    while (rsp_busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    compared++;
    if (pool_out_pvld !== 1'b0 || sum_in_pvld !== 1'b0 || sum_out_prdy !== 1'b0 ||
        pool_in_prdy !== 1'b1) begin
      mismatched++;
      $display("FAIL %s: out_pvld=%b sum_in_pvld=%b sum_out_prdy=%b in_prdy=%b, required 0 0 0 1",
               name, pool_out_pvld, sum_in_pvld, sum_out_prdy, pool_in_prdy);
    end
  endtask

  task automatic test_reset();
    autosa_core_rst = 1'b1;
    step();
    step();
    autosa_core_rst = 1'b0;
    check_idle_outputs("reset_state");
    compared++;
    if (pool_out_pd !== '0 || sum_a_pd !== '0 || sum_b_pd !== '0) begin
      mismatched++;
      $display("FAIL reset_data: out=%h a=%h b=%h, required all zero", pool_out_pd, sum_a_pd, sum_b_pd);
    end
  endtask

  task automatic test_k1();
    int nreq = req_a.size();
    cfg_kernel_width = 3'd0;
    send(17'h01234, 1'b0);
    compared++;
    if (pool_out_pvld !== 1'b1 || pool_out_pd !== vec(17'h01234)) begin
      mismatched++;
      $display("FAIL k1_latency: pvld=%b pd=%h, required pvld=1 pd=%h one cycle after accept",
               pool_out_pvld, pool_out_pd, vec(17'h01234));
    end
    get_out("k1_out", 17'h01234);
    compared++;
    if (req_a.size() != nreq) begin
      mismatched++;
      $display("FAIL k1_no_add: adder requests=%0d, required 0", req_a.size() - nreq);
    end
  endtask

  task automatic test_k4();
    int nreq = req_a.size();
    logic [FP17_W-1:0] ea[3] = '{17'd1, 17'd3, 17'd6};
    logic [FP17_W-1:0] eb[3] = '{17'd2, 17'd3, 17'd4};
    cfg_kernel_width = 3'd3;
    send(17'd1, 1'b0);
    cfg_kernel_width = 3'd0;
    send(17'd2, 1'b0);
    send(17'd3, 1'b0);
    send(17'd4, 1'b0);
    get_out("k4_out", 17'd10);
    compared++;
    if (req_a.size() - nreq != 3) begin
      mismatched++;
      $display("FAIL k4_req_count: requests=%0d, required 3", req_a.size() - nreq);
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (req_a[nreq+i] !== vec(ea[i]) || req_b[nreq+i] !== vec(eb[i])) begin
          mismatched++;
          $display("FAIL k4_req_%0d: a=%h b=%h, required a=%h b=%h", i, req_a[nreq+i],
                   req_b[nreq+i], vec(ea[i]), vec(eb[i]));
        end
      end
    end
  endtask

  task automatic test_last();
    int nreq = req_a.size();
    cfg_kernel_width = 3'd7;
    send(17'd5, 1'b0);
    send(17'd6, 1'b0);
    send(17'd7, 1'b1);
    get_out("last_out", 17'd18);
    compared++;
    if (req_a.size() - nreq != 2) begin
      mismatched++;
      $display("FAIL last_req_count: requests=%0d, required 2", req_a.size() - nreq);
    end
    nreq = req_a.size();
    cfg_kernel_width = 3'd1;
    send(17'h00100, 1'b0);
    send(17'h00020, 1'b0);
    get_out("fresh_cfg_out", 17'h00120);
    compared++;
    if (req_a.size() - nreq != 1) begin
      mismatched++;
      $display("FAIL fresh_cfg_req_count: requests=%0d, required 1", req_a.size() - nreq);
    end
    cfg_kernel_width = 3'd7;
    send(17'h1abcd, 1'b1);
    get_out("last_first_out", 17'h1abcd);
  endtask

  task automatic test_back_to_back();
    cfg_kernel_width = 3'd0;
    send(17'h00055, 1'b0);
    pool_in_pvld = 1'b1;
    pool_in_pd   = vec(17'h00077);
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (pool_out_pvld !== 1'b1 || pool_out_pd !== vec(17'h00055) || pool_in_prdy !== 1'b0) begin
        mismatched++;
        $display("FAIL out_hold_%0d: pvld=%b pd=%h in_prdy=%b, required 1 %h 0", i,
                 pool_out_pvld, pool_out_pd, pool_in_prdy, vec(17'h00055));
      end
      step();
    end
    pool_out_prdy = 1'b1;
    #1;
    compared++;
    if (pool_in_prdy !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_in_prdy: in_prdy=%b, required 1", pool_in_prdy);
    end
    step();
    pool_in_pvld  = 1'b0;
    pool_out_prdy = 1'b0;
    compared++;
    if (pool_out_pvld !== 1'b1 || pool_out_pd !== vec(17'h00077)) begin
      mismatched++;
      $display("FAIL b2b_new_window: pvld=%b pd=%h, required 1 %h", pool_out_pvld, pool_out_pd,
               vec(17'h00077));
    end
    get_out("b2b_out", 17'h00077);
  endtask

  task automatic test_adder_stall();
    int nreq = req_a.size();
    req_wait = 4;
    rsp_wait = 6;
    cfg_kernel_width = 3'd1;
    send(17'h00100, 1'b0);
    send(17'h00023, 1'b0);
    get_out("stall_out", 17'h00123);
    compared++;
    if (req_a.size() - nreq != 1) begin
      mismatched++;
      $display("FAIL stall_req_count: requests=%0d, required 1", req_a.size() - nreq);
    end
    req_wait = 0;
    rsp_wait = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rsp_wait = 6;
    cfg_kernel_width = 3'd1;
    send(17'd9, 1'b0);
    send(17'd9, 1'b0);
    while (sum_out_prdy !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    compared++;
    if (sum_out_prdy !== 1'b1) begin
      mismatched++;
      $display("FAIL reach_wait: sum_out_prdy=%b, required 1", sum_out_prdy);
    end
    autosa_core_rst = 1'b1;
    step();
    autosa_core_rst = 1'b0;
    check_idle_outputs("reset_in_wait");
    wait_adder_idle();
    rsp_wait = 0;
    send(17'd2, 1'b0);
    send(17'd3, 1'b0);
    get_out("after_reset_out", 17'd5);
  endtask

  initial begin
    autosa_core_rst  = 1'b1;
    cfg_kernel_width = 3'd0;
    pool_in_pvld     = 1'b0;
    pool_in_pd       = '0;
    pool_in_last     = 1'b0;
    pool_out_prdy    = 1'b0;
    test_reset();
    test_k1();
    test_k4();
    test_last();
    test_back_to_back();
    test_adder_stall();
    test_reset_mid();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cal1d_fp16_pool_seq.md
CAL1D_FP16_POOL_SEQ -- requirements
Module: cal1d_fp16_pool_seq

Interface
REQ-001 SHALL have port autosa_op_gated_clk_fp16, input, 1 bit: the single clock; all state on rising edge.
REQ-002 SHALL have port autosa_core_rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port cfg_kernel_width, input, 3 bits: pooling window K-1, so K = 1..8; sampled only when a window opens.
REQ-004 SHALL have ports pool_in_pvld (in, 1), pool_in_prdy (out, 1), pool_in_pd (in, 68 = 4 lanes x fp17, lane n at [17n+16:17n]) and pool_in_last (in, 1): input element stream; last closes the window early.
REQ-005 SHALL have ports sum_in_pvld (out, 1), sum_in_prdy (in, 1), sum_a_pd (out, 68) and sum_b_pd (out, 68): operand request to the external 4-lane fp17 pool adder.
REQ-006 SHALL have ports sum_out_pvld (in, 1), sum_out_prdy (out, 1) and sum_out_pd (in, 68): adder result return.
REQ-007 SHALL have ports pool_out_pvld (out, 1), pool_out_prdy (in, 1) and pool_out_pd (out, 68): pooled window sum.
REQ-008 SHALL drive every output from registers or from state decode only; no combinational path from any input to any output except pool_in_prdy in OUT (REQ-016).

Function
REQ-009 SHALL implement states IDLE, HOLD, ADD, WAIT, OUT, with registers partial[67:0], operand[67:0], cnt[2:0], klat[2:0] and close flag.
REQ-010 SHALL transfer on any interface only when pvld and prdy are both high in the same cycle.
REQ-011 IDLE: pool_in_prdy=1; on accept: partial<=pool_in_pd, cnt<=0, klat<=cfg_kernel_width; go OUT if klat==0 or pool_in_last, else HOLD.
REQ-012 HOLD: pool_in_prdy=1; on accept: operand<=pool_in_pd, close<=pool_in_last; go ADD.
REQ-013 ADD: sum_in_pvld=1, sum_a_pd=partial, sum_b_pd=operand, both stable until accepted; on sum_in_prdy go WAIT.
REQ-014 WAIT: sum_out_prdy=1; on sum_out_pvld: partial<=sum_out_pd, cnt<=cnt+1; go OUT if cnt+1==klat or close, else HOLD.
REQ-015 SHALL keep at most one addition in flight; sum_out_prdy=0 in all states except WAIT; sum_in_pvld=0 in all states except ADD.
REQ-016 OUT: pool_out_pvld=1, pool_out_pd=partial; pool_in_prdy=pool_out_prdy; on output accept with simultaneous input accept, the input SHALL open a new window per REQ-011 in the same cycle (no bubble); on output accept without input go IDLE.
REQ-017 SHALL pass fp17 data bit-exactly; the block performs no arithmetic on data.
REQ-018 Latency: K=1 window emits pool_out_pvld the cycle after input accept; a K-element window with a zero-wait, 1-cycle adder completes in 3K-1 cycles from first accept.
REQ-019 cfg_kernel_width changes mid-window SHALL have no effect until the next window opens.
REQ-020 pool_in_last on the first element SHALL emit that element unchanged, regardless of K.

Reset
REQ-021 On autosa_core_rst high at a clock edge: state<=IDLE, partial/operand<=0, cnt/klat<=0, close<=0; therefore pool_out_pvld=0, sum_in_pvld=0, sum_out_prdy=0, pool_in_prdy=1 from the following cycle.
REQ-022 Reset mid-window SHALL discard the partial sum and any in-flight request; the parent resets the adder with the same reset.

Structure
REQ-023 Shared package cal1d_pool_pkg SHALL hold FP17_W=17, POOL_LANES=4, POOL_VEC_W=68, KW_W=3 and the state enum.
REQ-024 SHALL contain no sub-module; cal1d_fp16_pool_sum is instantiated beside it by the parent, wired a/b/z to sum_a/sum_b/sum_out.

Verification
REQ-025 K=1 (cfg=0), input lanes 0x01234 -> pool_out_pd lanes 0x01234 one cycle later, no sum_in_pvld pulse.
REQ-026 K=4, inputs 1,2,3,4 with behavioural integer-add responder -> exactly 3 adder requests (1+2, 3+3, 6+4), output 10 in all lanes.
REQ-027 K=8, pool_in_last on 3rd element -> output after 2 adds, next window uses fresh cfg.
REQ-028 OUT with pool_out_prdy=0 for 5 cycles, then prdy=1 with pool_in_pvld=1 -> output held stable, new window opens in the accept cycle.
REQ-029 sum_in_prdy held low 4 cycles and sum_out_pvld delayed 6 cycles -> sum_a/sum_b stable, no second request, correct sum.
REQ-030 autosa_core_rst asserted in WAIT -> next cycle all valids 0, pool_in_prdy=1, next window result unaffected by discarded partial.
